// File: rtl/four_bit_comparator_unit.sv
// Registered 4-bit unsigned magnitude comparator. The raw eq/gt/lt relations
// come from an MSB-first cascade and are gated by independent query enables.

module four_bit_comparator_bit (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);
  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;
endmodule

module four_bit_comparator_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       isEqual,
  input  logic       isGreater,
  input  logic       isLess,
  output logic       equal,
  output logic       A_greater,
  output logic       A_less
);
  localparam int W = 4;

  logic [W-1:0] bit_eq, bit_gt, bit_lt;
  // *_above[i] summarizes bits W-1..i; index W is the empty prefix
  logic [W:0]   eq_above, gt_above, lt_above;

  for (genvar i = 0; i < W; i++) begin : g_bit
    four_bit_comparator_bit u_bit (
      .a  (A[i]),
      .b  (B[i]),
      .eq (bit_eq[i]),
      .gt (bit_gt[i]),
      .lt (bit_lt[i])
    );
  end

  assign eq_above[W] = 1'b1;
  assign gt_above[W] = 1'b0;
  assign lt_above[W] = 1'b0;

  // A lower bit only decides the outcome while every higher bit matched
  for (genvar i = W - 1; i >= 0; i--) begin : g_cascade
    assign eq_above[i] = eq_above[i+1] & bit_eq[i];
    assign gt_above[i] = gt_above[i+1] | (eq_above[i+1] & bit_gt[i]);
    assign lt_above[i] = lt_above[i+1] | (eq_above[i+1] & bit_lt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      equal     <= 1'b0;
      A_greater <= 1'b0;
      A_less    <= 1'b0;
    end else begin
      equal     <= isEqual   & eq_above[0];
      A_greater <= isGreater & gt_above[0];
      A_less    <= isLess    & lt_above[0];
    end
  end
endmodule

// File: tb/tb_four_bit_comparator_unit.sv
// Bench for four_bit_comparator_unit: directed cases, async reset behaviour,
// an exhaustive operand/enable sweep and random traffic against an arithmetic model.

module tb_four_bit_comparator_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       isEqual = 1'b0, isGreater = 1'b0, isLess = 1'b0;
  logic       equal, A_greater, A_less;

  int passed = 0;
  int total  = 0;

  four_bit_comparator_unit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .isEqual   (isEqual),
    .isGreater (isGreater),
    .isLess    (isLess),
    .equal     (equal),
    .A_greater (A_greater),
    .A_less    (A_less)
  );

  always #5 clk = ~clk;

  // Reference: enables ordered {eq, gt, lt}, result ordered {equal, A_greater, A_less}
  function automatic logic [2:0] model(int a, int b, logic [2:0] en);
    return {en[2] & (a == b), en[1] & (a > b), en[0] & (a < b)};
  endfunction

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {equal, A_greater, A_less};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b (A=%h B=%h en=%b%b%b)",
                tag, obs, exp, A, B, isEqual, isGreater, isLess);
  endtask

  // Drive a compare, let one rising edge capture it, then check just after the edge
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] en, input logic [2:0] exp);
    A = a;
    B = b;
    {isEqual, isGreater, isLess} = en;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    A = 4'h3; B = 4'h3; {isEqual, isGreater, isLess} = 3'b100;
    #1 rst = 1'b1;
    #1 check("reset_async", 3'b000);
    @(posedge clk);
    #1 check("reset_hold", 3'b000);
    #2 rst = 1'b0;

    apply("t2_eq00",      4'h0, 4'h0, 3'b100, 3'b100);
    apply("t2_gt55",      4'h5, 4'h5, 3'b010, 3'b000);
    apply("t2_lt55",      4'h5, 4'h5, 3'b001, 3'b000);
    apply("t3_eqFC",      4'hF, 4'hC, 3'b100, 3'b000);
    apply("t3_gtFC",      4'hF, 4'hC, 3'b010, 3'b010);
    apply("t3_ltF6",      4'hF, 4'h6, 3'b001, 3'b000);
    apply("t4_eq3C",      4'h3, 4'hC, 3'b100, 3'b000);
    apply("t4_gt3C",      4'h3, 4'hC, 3'b010, 3'b000);
    apply("t4_lt3C",      4'h3, 4'hC, 3'b001, 3'b001);
    apply("t5_none",      4'hC, 4'h3, 3'b000, 3'b000);
    apply("t5_all",       4'hC, 4'h3, 3'b111, 3'b010);
    apply("bnd_FF",       4'hF, 4'hF, 3'b111, 3'b100);
    apply("bnd_F0",       4'hF, 4'h0, 3'b111, 3'b010);
    apply("bnd_0F",       4'h0, 4'hF, 3'b111, 3'b001);
    apply("bnd_msb",      4'h8, 4'h7, 3'b111, 3'b010);
    apply("bnd_msb_rev",  4'h7, 4'h8, 3'b111, 3'b001);

    // Reset mid-operation clears a live 1 immediately and discards the pending sample
    apply("pre_rst",      4'h9, 4'h9, 3'b100, 3'b100);
    #2 rst = 1'b1;
    #1 check("rst_mid_async", 3'b000);
    @(posedge clk);
    #1 check("rst_mid_hold", 3'b000);
    #2 rst = 1'b0;
    apply("post_rst",     4'h2, 4'h1, 3'b010, 3'b010);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int e = 0; e < 8; e++)
          apply("exhaustive", 4'(a), 4'(b), 3'(e), model(a, b, 3'(e)));

    for (int n = 0; n < 400; n++) begin
      int ra, rb, re;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      re = int'($urandom_range(7, 0));
      apply("random", 4'(ra), 4'(rb), 3'(re), model(ra, rb, 3'(re)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
